// File: rtl/dsp_accum_pkg.sv
// Shared definitions for the product accumulator: default widths and the
// result-handshake state encoding.
package dsp_accum_pkg;

  localparam int unsigned PROD_WIDTH_DEF = 54;
  localparam int unsigned ACC_WIDTH_DEF  = 64;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  // ACCUM: collecting terms, no result pending; HOLD: result presented.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/dsp_sat_add.sv
// Unsigned adder that clamps to all-ones on carry-out and reports the carry.
module dsp_sat_add #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign carry    = full_sum[WIDTH];
  assign sum      = carry ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];

endmodule

// File: rtl/dsp_27x27u_accum.sv
// Frame accumulator behind the 27x27 unsigned multiplier: sums product terms
// up to prod_last and presents a saturating result with a valid/ready handshake.
module dsp_27x27u_accum
  import dsp_accum_pkg::*;
#(
  parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PROD_WIDTH-1:0] prod,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic [CNT_WIDTH-1:0]  sum_count,
  output logic                  sum_ovf,
  output logic                  sum_valid,
  input  logic                  sum_ready
);

  if (ACC_WIDTH < PROD_WIDTH) begin : g_width_check
    $error("dsp_27x27u_accum: ACC_WIDTH must be >= PROD_WIDTH");
  end

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_WIDTH-1:0]   sum_count_q, sum_count_d;
  logic                   sum_ovf_q, sum_ovf_d;

  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   add_carry;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   ovf_next;
  logic                   accept;
  logic                   accept_last;

  assign sum_valid   = (state_q == HOLD);
  assign prod_ready  = !sum_valid || sum_ready;
  assign accept      = prod_valid && prod_ready;
  assign accept_last = accept && prod_last;

  assign prod_ext = ACC_WIDTH'(prod);

  dsp_sat_add #(
    .WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .a     (acc_q),
    .b     (prod_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Counter sticks at all-ones so a very long frame reports the maximum, not a wrapped value.
  assign cnt_inc  = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign ovf_next = ovf_q || add_carry;

  // NOTE: every _d is given its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    sum_count_d = sum_count_q;
    sum_ovf_d   = sum_ovf_q;

    case (state_q)
      ACCUM:   if (accept_last) state_d = HOLD;
      HOLD:    if (!accept_last && sum_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase

    if (accept) begin
      if (prod_last) begin
        // Final term goes straight to the result registers; the accumulator restarts empty.
        sum_d       = add_sum;
        sum_count_d = cnt_inc;
        sum_ovf_d   = ovf_next;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = add_sum;
        cnt_d = cnt_inc;
        ovf_d = ovf_next;
      end
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      sum_count_q <= '0;
      sum_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      sum_count_q <= sum_count_d;
      sum_ovf_q   <= sum_ovf_d;
    end
  end

  assign sum       = sum_q;
  assign sum_count = sum_count_q;
  assign sum_ovf   = sum_ovf_q;

endmodule
